action_encoder: RTL and testbench
=================================

// Module: action_encoder
// PURPOSE
//   Converts the raw left/right push-buttons into the frame-aligned actions[1:0] bus that feeds the game top level.
//   Each button is synchronised, debounced and auto-repeated (delayed auto-shift).
//   Move events are accumulated per frame and presented on actions for exactly one frame.
//   The frame starts at each vsync rising edge, and vsync comes from the VGA controller on the same clock.
//   Sits between the board buttons and the game logic, which reads actions once per frame.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000  consecutive stable clock cycles before a debounced level change is accepted (>=1)
//   REPEAT_DELAY     16      frames a button must be held before the first auto-repeat; 0 disables auto-repeat
//   REPEAT_PERIOD    6       frames between auto-repeats once repeating (>=1)
//   CNT_W            18      width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clock        in   1   system clock, shared with the VGA controller
//   reset_n      in   1   asynchronous active-low reset
//   btn_right    in   1   raw right button, asynchronous, active-high
//   btn_left     in   1   raw left button, asynchronous, active-high
//   vsync        in   1   VGA vsync; a rising edge marks a frame boundary
//   actions      out  2   bit0 = right, bit1 = left; valid for one full frame
//   conflict     out  1   1-cycle pulse: left and right were both pending at a frame boundary
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - actions=2'b00, conflict=0.
//     - Synchronisers, debounced levels, vsync_d, counters, pending bits and FSMs all cleared.
//     - Each FSM goes to IDLE.
//     - Reset mid-hold: after release of reset a still-held button is treated as a new press.
//       It must first pass debounce again.
//   Synchronisation: two flip-flops per button. Raw-to-synchronised latency is 2 cycles.
//   Debounce (per button):
//     - Counter resets to 0 whenever the synchronised input equals the debounced level.
//     - Otherwise the counter increments.
//     - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
//     - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
//   frame_tick:
//     - vsync_d is vsync registered once; frame_tick = vsync & ~vsync_d.
//     - frame_tick is exactly one cycle per vsync rising edge.
//   Per-button FSM {IDLE, DELAY, REPEAT}:
//     - IDLE: on the debounced rising edge, emit one event and go to DELAY with frame count = 0.
//     - DELAY: count frame_ticks. When the count reaches REPEAT_DELAY, emit an event, go to REPEAT and clear the count.
//     - DELAY with REPEAT_DELAY=0: stay in DELAY and never repeat.
//     - REPEAT: count frame_ticks. On each count of REPEAT_PERIOD, emit an event and clear the count.
//     - From DELAY or REPEAT, a debounced release returns the FSM to IDLE and clears the count.
//     - Events already pending are kept on release.
//   Pending bits:
//     - An event sets pending[i].
//     - Several events within one frame collapse to one; there is no counting.
//   Frame boundary (cycle with frame_tick=1):
//     - actions <= pending, registered; visible the cycle after frame_tick.
//     - actions is held unchanged until the next frame_tick.
//     - If pending==2'b11: actions <= 2'b00 and conflict=1 for that one cycle.
//     - pending <= events generated in that same cycle, so a simultaneous event goes to the next frame and is never lost.
//   Repeat counting: an event emitted on a frame_tick (repeat) lands in the following frame's actions.
//   Latency, press to actions: 2 + DEBOUNCE_CYCLES cycles to the event.
//     - The event then appears one cycle after the next frame_tick.
//   No frame without vsync: if vsync never toggles, pending is held indefinitely and actions stays constant.
// TESTING (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2; vsync rises every 100 cycles)
//   1. Debounce and latency:
//      - Stimulus: btn_right 0->1 at cycle 10.
//      - Response: event at cycle 16; actions=2'b01 from the cycle after the next vsync rise, for exactly one frame, then 2'b00.
//   2. Glitch rejection:
//      - Stimulus: btn_left high for 3 cycles, then low.
//      - Response: actions stays 2'b00 for 3 frames; the FSM never leaves IDLE.
//   3. Auto-repeat:
//      - Stimulus: hold btn_right for 10 frames.
//      - Response: actions=01 in frame 1 (press), then 00,00, then 01 at frame 4, then 01 every 2nd frame (6, 8, 10).
//   4. Conflict:
//      - Stimulus: press left and right within the same frame.
//      - Response: next frame actions=2'b00 and conflict pulses high for one cycle.
//   5. Simultaneous edge:
//      - Stimulus: the debounced press event coincides with the frame_tick cycle.
//      - Response: actions is 00 for that frame; 01 in the following frame.
//   6. Async reset mid-hold:
//      - Stimulus: btn_right held in REPEAT; pulse reset_n low for 1 cycle.
//      - Response: actions=00 and conflict=0 immediately.
//      - Response: after reset a fresh press event follows 2+4 cycles later and shows in the next frame.

Source files
------------

// File: rtl/action_encoder_if.sv
// action_encoder_if
//   Groups the button/vsync inputs and the frame-aligned action outputs of
//   action_encoder into one bundle.
//   Signals:
//     btn_right, btn_left  raw push-buttons, asynchronous, active-high
//     vsync                VGA vsync on the system clock; a rising edge starts a frame
//     actions[1:0]         bit0 = right, bit1 = left; stable for one frame
//     conflict             one-cycle pulse when both moves were pending at a frame boundary
//   Modports: master drives the buttons/vsync (board side or bench),
//             slave is the encoder itself.
interface action_encoder_if;
  logic       btn_right;
  logic       btn_left;
  logic       vsync;
  logic [1:0] actions;
  logic       conflict;

  modport master (output btn_right, btn_left, vsync, input actions, conflict);
  modport slave  (input btn_right, btn_left, vsync, output actions, conflict);
endinterface

// File: rtl/action_encoder.sv
// action_encoder
//   Turns the raw left/right buttons into a frame-aligned actions[1:0] bus.
//   Each button is synchronised (2 FFs), debounced and auto-repeated in its
//   own action_btn lane; lane events are collected into pending bits and
//   transferred to actions on each vsync rising edge (frame_tick).
//   Ports:
//     clock    system clock, shared with the VGA controller
//     reset_n  asynchronous active-low reset
//     bus      action_encoder_if.slave (btn_right, btn_left, vsync in;
//              actions, conflict out)

// action_btn: one button lane -- synchroniser, debouncer and the
// IDLE/DELAY/REPEAT auto-repeat FSM. o_event is a one-cycle event strobe.
//   clock, reset_n  clock / async active-low reset
//   i_raw           raw asynchronous button level
//   i_frame_tick    one-cycle pulse at each frame start
//   o_event         move event for this button
module action_btn #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 6,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_raw,
  input  logic i_frame_tick,
  output logic o_event
);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int FC_W = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The frame counter holds ticks-so-far minus one, so the match value is N-1.
  localparam logic [FC_W-1:0]  RD_LAST = (REPEAT_DELAY == 0) ? '0 : FC_W'(REPEAT_DELAY - 1);
  localparam logic [FC_W-1:0]  RP_LAST = FC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [1:0]       r_sync;
  logic             w_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             w_flip;
  logic             w_rise;
  logic             w_fall;
  state_t           r_state, w_state_nxt;
  logic [FC_W-1:0]  r_fcnt, w_fcnt_nxt;
  logic             w_event;

  assign w_sync = r_sync[1];
  // Flip on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  assign w_flip = (w_sync != r_db) && (r_cnt == DB_LAST);
  assign w_rise = w_flip & ~r_db;
  assign w_fall = w_flip &  r_db;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (w_sync == r_db) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_event     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_event     = 1'b1;
          w_state_nxt = S_DELAY;
          w_fcnt_nxt  = '0;
        end
      end
      S_DELAY: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_fcnt_nxt  = '0;
        end else if (i_frame_tick && (REPEAT_DELAY != 0)) begin
          if (r_fcnt == RD_LAST) begin
            w_event     = 1'b1;
            w_state_nxt = S_REPEAT;
            w_fcnt_nxt  = '0;
          end else begin
            w_fcnt_nxt = r_fcnt + FC_W'(1);
          end
        end
      end
      S_REPEAT: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_fcnt_nxt  = '0;
        end else if (i_frame_tick) begin
          if (r_fcnt == RP_LAST) begin
            w_event    = 1'b1;
            w_fcnt_nxt = '0;
          end else begin
            w_fcnt_nxt = r_fcnt + FC_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  assign o_event = w_event;
endmodule

module action_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 6,
  parameter int CNT_W           = 18
) (
  input  logic          clock,
  input  logic          reset_n,
  action_encoder_if.slave bus
);
  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_event;
  logic               r_vsync_d;
  logic               w_frame_tick;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_actions;
  logic               r_conflict;

  // Lane 0 = right, lane 1 = left, matching the actions bit order.
  assign w_raw        = {bus.btn_left, bus.btn_right};
  assign w_frame_tick = bus.vsync & ~r_vsync_d;

  action_btn #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_btn [NUM_BTN-1:0] (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_raw        (w_raw),
    .i_frame_tick (w_frame_tick),
    .o_event      (w_event)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d  <= 1'b0;
      r_pending  <= '0;
      r_actions  <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_vsync_d <= bus.vsync;
      if (w_frame_tick) begin
        // Opposite moves in one frame cancel; flag it instead.
        r_actions  <= (&r_pending) ? '0 : r_pending;
        r_conflict <= &r_pending;
        // Events on the boundary cycle belong to the next frame.
        r_pending  <= w_event;
      end else begin
        r_pending  <= r_pending | w_event;
        r_conflict <= 1'b0;
      end
    end
  end

  assign bus.actions  = r_actions;
  assign bus.conflict = r_conflict;
endmodule

// File: tb/tb_action_encoder.sv
module tb_action_encoder;
  localparam int DEB = 4;
  localparam int RD  = 3;
  localparam int RP  = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   conf_seen = 0;

  action_encoder_if ae_if ();

  action_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ae_if)
  );

  always #5 clock = ~clock;

  // Reference model: debounce as a run length of disagreeing samples,
  // auto-repeat as "frames held since press" arithmetic.
  bit [1:0] m_s1, m_s2, m_db, m_held, m_pend, m_act, m_raw, m_ev, m_chg;
  int       m_run [2];
  int       m_k   [2];
  bit       m_conf, m_vd, m_tick;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_held = 0; m_pend = 0; m_act = 0;
      m_conf = 0; m_vd = 0;
      for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_k[i] = 0; end
    end else begin
      m_raw  = {ae_if.btn_left, ae_if.btn_right};
      m_tick = ae_if.vsync && !m_vd;
      m_vd   = ae_if.vsync;
      m_ev   = 0;
      m_chg  = 0;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_run[i] = 0;
            m_db[i]  = !m_db[i];
            m_chg[i] = 1;
            if (m_db[i]) begin m_ev[i] = 1; m_held[i] = 1; m_k[i] = 0; end
            else m_held[i] = 0;
          end
        end
        if (!m_chg[i] && m_held[i] && m_tick) begin
          m_k[i]++;
          if (RD != 0 && (m_k[i] == RD || (m_k[i] > RD && ((m_k[i] - RD) % RP) == 0)))
            m_ev[i] = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_raw;
      if (m_tick) begin
        m_conf = (m_pend == 2'b11);
        m_act  = m_conf ? 2'b00 : m_pend;
        m_pend = m_ev;
      end else begin
        m_pend = m_pend | m_ev;
        m_conf = 0;
      end
    end
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // One cycle: vsync rises every 100 cycles; outputs checked against the model.
  task automatic step();
    @(negedge clock);
    cyc++;
    ae_if.vsync = (cyc % 100) < 50;
    check("model_actions", ae_if.actions, m_act);
    check("model_conflict", {1'b0, ae_if.conflict}, {1'b0, m_conf});
    if (ae_if.conflict === 1'b1) conf_seen++;
  endtask

  task automatic wait_phase(input int p);
    for (int n = 0; n < 100 && (cyc % 100) != p; n++) step();
  endtask

  typedef struct {
    string           name;
    bit              r;
    bit              l;
    int              hold;
    bit [11:0][1:0]  exp;
    int              conf;
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input vec_t v);
    int f;
    f = 0;
    conf_seen = 0;
    wait_phase(10);
    ae_if.btn_right = v.r;
    ae_if.btn_left  = v.l;
    for (int s = 1; s <= 1140; s++) begin
      step();
      if (s == v.hold) begin ae_if.btn_right = 0; ae_if.btn_left = 0; end
      if ((cyc % 100) == 50 && f < 12) begin
        check($sformatf("%s_f%0d", v.name, f), ae_if.actions, v.exp[f]);
        f++;
      end
    end
    check({v.name, "_conflicts"}, 2'(conf_seen), 2'(v.conf));
  endtask

  initial begin
    ae_if.btn_right = 0;
    ae_if.btn_left  = 0;
    ae_if.vsync     = 0;

    for (int i = 0; i < 6; i++) begin vt[i].exp = '0; vt[i].r = 0; vt[i].l = 0; vt[i].conf = 0; end
    vt[0].name = "press_right"; vt[0].r = 1; vt[0].hold = 30;  vt[0].exp[1] = 2'b01;
    vt[1].name = "glitch_left"; vt[1].l = 1; vt[1].hold = 3;
    vt[2].name = "repeat";      vt[2].r = 1; vt[2].hold = 1000;
    vt[2].exp[1] = 2'b01; vt[2].exp[4] = 2'b01; vt[2].exp[6] = 2'b01;
    vt[2].exp[8] = 2'b01; vt[2].exp[10] = 2'b01;
    vt[3].name = "conflict";    vt[3].r = 1; vt[3].l = 1; vt[3].hold = 30; vt[3].conf = 1;
    vt[4].name = "press_left";  vt[4].l = 1; vt[4].hold = 30;  vt[4].exp[1] = 2'b10;
    vt[5].name = "first_rep";   vt[5].r = 1; vt[5].hold = 350;
    vt[5].exp[1] = 2'b01; vt[5].exp[4] = 2'b01;

    repeat (3) step();
    check("reset_actions", ae_if.actions, 2'b00);
    check("reset_conflict", {1'b0, ae_if.conflict}, 2'b00);
    reset_n = 1;
    repeat (250) step();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Press strobe lands on the frame_tick cycle: deferred by one frame.
    wait_phase(95);
    ae_if.btn_right = 1;
    for (int s = 1; s <= 230; s++) begin
      step();
      if (s == 30) ae_if.btn_right = 0;
      if (s == 55)  check("simul_frameA", ae_if.actions, 2'b00);
      if (s == 155) check("simul_frameB", ae_if.actions, 2'b01);
    end

    // Reset while auto-repeating, in a frame showing a move.
    wait_phase(10);
    ae_if.btn_right = 1;
    repeat (460) step();
    check("pre_reset_actions", ae_if.actions, 2'b01);
    reset_n = 0;
    #1;
    check("rst_mid_actions", ae_if.actions, 2'b00);
    check("rst_mid_conflict", {1'b0, ae_if.conflict}, 2'b00);
    step();
    reset_n = 1;
    for (int s = 1; s <= 200; s++) begin
      step();
      if (s == 19)  check("post_rst_same_frame", ae_if.actions, 2'b00);
      if (s == 79)  check("post_rst_next_frame", ae_if.actions, 2'b01);
      if (s == 179) check("post_rst_frame2", ae_if.actions, 2'b00);
    end
    ae_if.btn_right = 0;

    // Random button activity against the model.
    for (int n = 0; n < 60; n++) begin
      ae_if.btn_right = 1'($urandom_range(0, 1));
      ae_if.btn_left  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 120)) step();
    end
    ae_if.btn_right = 0;
    ae_if.btn_left  = 0;
    repeat (300) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
